// File: rtl/fifo_pkg.sv
// Shared defaults and status-state encoding for the 8x16 FIFO controller.
package fifo_pkg;

  localparam int FIFO_WIDTH    = 16;
  localparam int FIFO_DEPTH    = 8;
  localparam int FIFO_ADDR_BUS = 3;
  localparam int FIFO_AF_LEVEL = 6;
  localparam int FIFO_AE_LEVEL = 2;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } fifo_state_e;

endpackage

// File: rtl/fifo_ctrl_8x16_if.sv
// Producer/consumer handshake, status and RAM-side bus of the FIFO controller.
interface fifo_ctrl_8x16_if
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH,
  parameter int ADDR_BUS = FIFO_ADDR_BUS
);

  logic                push;
  logic [WIDTH-1:0]    wr_data;
  logic                pop;
  logic                flush;
  logic                full;
  logic                empty;
  logic                almost_full;
  logic                almost_empty;
  logic [ADDR_BUS:0]   count;
  logic                overflow;
  logic                underflow;
  logic [WIDTH-1:0]    rd_data;
  logic                rd_valid;
  logic                ram_we;
  logic                ram_re;
  logic [ADDR_BUS-1:0] ram_wr_addr;
  logic [ADDR_BUS-1:0] ram_rd_addr;
  logic [WIDTH-1:0]    ram_din;
  logic [WIDTH-1:0]    ram_dout;

  modport slave (
    input  push, wr_data, pop, flush, ram_dout,
    output full, empty, almost_full, almost_empty, count, overflow, underflow,
           rd_data, rd_valid, ram_we, ram_re, ram_wr_addr, ram_rd_addr, ram_din
  );

  modport master (
    output push, wr_data, pop, flush, ram_dout,
    input  full, empty, almost_full, almost_empty, count, overflow, underflow,
           rd_data, rd_valid, ram_we, ram_re, ram_wr_addr, ram_rd_addr, ram_din
  );

endinterface

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer: ADDR_BUS+1-bit incrementer with enable and synchronous clear.
module fifo_ptr #(
  parameter int ADDR_BUS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  output logic [ADDR_BUS:0] ptr
);

  localparam int PW = ADDR_BUS + 1;

  logic [ADDR_BUS:0] ptr_d;
  logic [ADDR_BUS:0] ptr_q;

  // Clear wins over advance; the increment wraps naturally through the MSB.
  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (en) begin
      ptr_d = ptr_q + PW'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl_8x16.sv
// Pointer/flag controller that turns an 8x16 dual-port RAM into a synchronous FIFO.
module fifo_ctrl_8x16
  import fifo_pkg::*;
#(
  parameter int WIDTH    = FIFO_WIDTH,
  parameter int DEPTH    = FIFO_DEPTH,
  parameter int ADDR_BUS = FIFO_ADDR_BUS,
  parameter int AF_LEVEL = FIFO_AF_LEVEL,
  parameter int AE_LEVEL = FIFO_AE_LEVEL
) (
  input logic             clk,
  input logic             rst,
  fifo_ctrl_8x16_if.slave bus
);

  localparam int PW = ADDR_BUS + 1;
  localparam logic [ADDR_BUS:0] CNT_ONE  = PW'(1);
  localparam logic [ADDR_BUS:0] CNT_LAST = PW'(DEPTH - 1);
  localparam logic [ADDR_BUS:0] AF_C     = PW'(AF_LEVEL);
  localparam logic [ADDR_BUS:0] AE_C     = PW'(AE_LEVEL);

  logic [ADDR_BUS:0] wr_ptr_s;
  logic [ADDR_BUS:0] rd_ptr_s;
  logic [ADDR_BUS:0] count_s;
  logic              full_s;
  logic              empty_s;
  logic              push_ok_s;
  logic              pop_ok_s;
  logic [WIDTH-1:0]  din_s;
  logic [WIDTH-1:0]  dout_s;

  fifo_state_e state_d;
  fifo_state_e state_q;
  logic        overflow_d;
  logic        overflow_q;
  logic        underflow_d;
  logic        underflow_q;
  logic        rd_valid_d;
  logic        rd_valid_q;

  // full/empty come from the state register, which tracks count exactly.
  assign full_s    = (state_q == ST_FULL);
  assign empty_s   = (state_q == ST_EMPTY);
  assign push_ok_s = bus.push & ~full_s & ~bus.flush;
  assign pop_ok_s  = bus.pop & ~empty_s & ~bus.flush;
  assign count_s   = wr_ptr_s - rd_ptr_s;

  fifo_ptr #(.ADDR_BUS(ADDR_BUS)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .en  (push_ok_s),
    .ptr (wr_ptr_s)
  );

  fifo_ptr #(.ADDR_BUS(ADDR_BUS)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (bus.flush),
    .en  (pop_ok_s),
    .ptr (rd_ptr_s)
  );

  // Status FSM next state plus sticky error and read-valid bookkeeping.
  always_comb begin
    state_d     = state_q;
    overflow_d  = overflow_q | (bus.push & full_s);
    underflow_d = underflow_q | (bus.pop & empty_s);
    rd_valid_d  = pop_ok_s;
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_ok_s) begin
            state_d = ST_PARTIAL;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_PARTIAL: begin
          if (push_ok_s && !pop_ok_s && (count_s == CNT_LAST)) begin
            state_d = ST_FULL;
          end else if (pop_ok_s && !push_ok_s && (count_s == CNT_ONE)) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_PARTIAL;
          end
        end
        ST_FULL: begin
          if (pop_ok_s) begin
            state_d = ST_PARTIAL;
          end else begin
            state_d = ST_FULL;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign din_s  = bus.wr_data;
  assign dout_s = bus.ram_dout;

  assign bus.ram_we       = push_ok_s;
  assign bus.ram_re       = pop_ok_s;
  assign bus.ram_wr_addr  = wr_ptr_s[ADDR_BUS-1:0];
  assign bus.ram_rd_addr  = rd_ptr_s[ADDR_BUS-1:0];
  assign bus.ram_din      = din_s;
  assign bus.rd_data      = dout_s;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.full         = full_s;
  assign bus.empty        = empty_s;
  assign bus.almost_full  = (count_s >= AF_C);
  assign bus.almost_empty = (count_s <= AE_C);
  assign bus.count        = count_s;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl_8x16.sv
// Randomised scoreboard bench for fifo_ctrl_8x16 with a queue-based FIFO model and a behavioural RAM.
module tb_fifo_ctrl_8x16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fifo_ctrl_8x16_if ifc ();

  fifo_ctrl_8x16 dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  // Behavioural 8x16 RAM: writes and reads sampled on the rising edge, dout valid next cycle.
  logic [15:0] mem [0:7];
  always @(posedge clk) begin
    if (ifc.ram_we === 1'b1) mem[ifc.ram_wr_addr] <= ifc.ram_din;
    if (ifc.ram_re === 1'b1) ifc.ram_dout <= mem[ifc.ram_rd_addr];
  end

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] mq[$];   // reference FIFO contents
  logic [15:0] sb[$];   // words awaiting rd_valid
  int  wr_total = 0;
  int  rd_total = 0;
  bit  ovf = 1'b0;
  bit  udf = 1'b0;
  bit  rv_exp = 1'b0;
  bit  known = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid must deliver the oldest outstanding popped word.
  always @(negedge clk) begin
    if (ifc.rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rd_valid_spurious: got rd_valid=1 expected no pending read at %0t", $time);
      end else begin
        chk("rd_data", {16'd0, ifc.rd_data}, {16'd0, sb.pop_front()});
      end
    end
  end

  task automatic cycle(input logic p, input logic [15:0] d, input logic q,
                       input logic f, input logic r);
    int n;
    bit push_ok;
    bit pop_ok;
    ifc.push    = p;
    ifc.wr_data = d;
    ifc.pop     = q;
    ifc.flush   = f;
    rst         = r;
    @(negedge clk);
    n       = mq.size();
    push_ok = p && (n < 8) && !f;
    pop_ok  = q && (n > 0) && !f;
    if (known) begin
      chk("count", {28'd0, ifc.count}, n);
      chk("full", {31'd0, ifc.full}, {31'd0, n == 8});
      chk("empty", {31'd0, ifc.empty}, {31'd0, n == 0});
      chk("almost_full", {31'd0, ifc.almost_full}, {31'd0, n >= 6});
      chk("almost_empty", {31'd0, ifc.almost_empty}, {31'd0, n <= 2});
      chk("overflow", {31'd0, ifc.overflow}, {31'd0, ovf});
      chk("underflow", {31'd0, ifc.underflow}, {31'd0, udf});
      chk("rd_valid", {31'd0, ifc.rd_valid}, {31'd0, rv_exp});
      if (!r) begin
        chk("ram_we", {31'd0, ifc.ram_we}, {31'd0, push_ok});
        chk("ram_re", {31'd0, ifc.ram_re}, {31'd0, pop_ok});
        chk("ram_wr_addr", {29'd0, ifc.ram_wr_addr}, wr_total % 8);
        chk("ram_rd_addr", {29'd0, ifc.ram_rd_addr}, rd_total % 8);
        if (push_ok) chk("ram_din", {16'd0, ifc.ram_din}, {16'd0, d});
      end
    end
    if (r) begin
      mq.delete();
      wr_total = 0;
      rd_total = 0;
      ovf      = 1'b0;
      udf      = 1'b0;
      rv_exp   = 1'b0;
      known    = 1'b1;
    end else begin
      if (p && n == 8) ovf = 1'b1;
      if (q && n == 0) udf = 1'b1;
      if (f) begin
        mq.delete();
        wr_total = 0;
        rd_total = 0;
        rv_exp   = 1'b0;
      end else begin
        if (pop_ok) begin
          sb.push_back(mq.pop_front());
          rd_total++;
        end
        if (push_ok) begin
          mq.push_back(d);
          wr_total++;
        end
        rv_exp = pop_ok;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    ifc.push    = 1'b0;
    ifc.wr_data = 16'h0000;
    ifc.pop     = 1'b0;
    ifc.flush   = 1'b0;
    @(posedge clk);
    #1;

    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Fill with 1..8, then push while full.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hDEAD, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'hBEEF, 1'b1, 1'b0, 1'b0);

    // Drain, then pop while empty.
    for (int i = 0; i < 8; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Concurrent push/pop at count 3 across the pointer wrap.
    for (int i = 0; i < 3; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 16'($urandom), 1'b1, 1'b0, 1'b0);

    // Flush at count 5 with push and pop also requested.
    for (int i = 0; i < 2; i++) cycle(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 16'h1234, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Pop requested in a reset cycle must not produce rd_valid.
    cycle(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) == 0));
    end

    for (int i = 0; i < 10; i++) cycle(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("pending_reads", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl_8x16.md
# fifo_ctrl_8x16

Pointer/flag controller that sits directly upstream of the 8x16 dual-port RAM and turns it into a synchronous FIFO. It accepts push/pop requests from the producer and consumer, generates the RAM's `we`/`re`/`wr_addr`/`rd_addr`/`din`, and returns RAM read data with a valid strobe. It also provides full/empty, almost-full/almost-empty and occupancy status, plus sticky error flags.

## Interface

**Parameters**
- `WIDTH`, 16: data width.
- `DEPTH`, 8: RAM entries; must equal 2**ADDR_BUS.
- `ADDR_BUS`, 3: RAM address width.
- `AF_LEVEL`, 6: `almost_full` asserts when count >= AF_LEVEL.
- `AE_LEVEL`, 2: `almost_empty` asserts when count <= AE_LEVEL.

**Ports**
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `push`  in  1: write request.
- `wr_data`  in  WIDTH: data to write.
- `pop`  in  1: read request.
- `flush`  in  1: synchronous clear of FIFO contents.
- `full`  out  1: count == DEPTH.
- `empty`  out  1: count == 0.
- `almost_full`  out  1: count >= AF_LEVEL.
- `almost_empty`  out  1: count <= AE_LEVEL.
- `count`  out  ADDR_BUS+1: occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; set by push while full.
- `underflow`  out  1: sticky; set by pop while empty.
- `rd_data`  out  WIDTH: equals `ram_dout`.
- `rd_valid`  out  1: `rd_data` holds the popped word.
- `ram_we`  out  1: RAM write enable.
- `ram_re`  out  1: RAM read enable.
- `ram_wr_addr`  out  ADDR_BUS: RAM write address.
- `ram_rd_addr`  out  ADDR_BUS: RAM read address.
- `ram_din`  out  WIDTH: RAM write data.
- `ram_dout`  in  WIDTH: RAM read data.

## Operation
- **Pointers.** `wr_ptr` and `rd_ptr` are ADDR_BUS+1 bits. The low bits address the RAM; the MSB is the wrap bit.
- **Count.** `count = wr_ptr - rd_ptr`, computed modulo 2**(ADDR_BUS+1).
- **Full/empty.**
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.
- **Accept rules.**
  - `push_ok = push & ~full & ~flush`
  - `pop_ok = pop & ~empty & ~flush`
- **RAM drive (combinational).**
  - `ram_we = push_ok`, `ram_wr_addr = wr_ptr[ADDR_BUS-1:0]`, `ram_din = wr_data`.
  - `ram_re = pop_ok`, `ram_rd_addr = rd_ptr[ADDR_BUS-1:0]`.
- **Pointer advance.** On push_ok, `wr_ptr` increments; on pop_ok, `rd_ptr` increments. Both wrap naturally at 2**(ADDR_BUS+1).
- **Simultaneous push_ok and pop_ok.** Both pointers advance and count is unchanged.
- **Boundary conditions.**
  - Full: pop is accepted; push is rejected even if pop is accepted in the same cycle. No same-address read/write collision occurs.
  - Empty: push is accepted; pop is rejected. There is no fall-through.
  - Push while full sets `overflow`; pop while empty sets `underflow`. Both flags hold until `rst`.
- **Flush.** Sets both pointers to 0 and clears `rd_valid`. It has priority over push and pop (`ram_we` and `ram_re` are 0 that cycle). It does not clear `overflow` or `underflow`. RAM contents are not erased.
- **Status FSM.** Three states: EMPTY, PARTIAL, FULL.
  - EMPTY -> PARTIAL on push_ok.
  - PARTIAL -> FULL when count goes DEPTH-1 -> DEPTH.
  - FULL -> PARTIAL on pop_ok.
  - PARTIAL -> EMPTY when count goes 1 -> 0.
  - Any state -> EMPTY on flush or rst.
  - `full` and `empty` are decoded from the state register; this must always agree with `count`.

## Timing
- **Reset values** (after the rising edge with `rst=1`):
  - pointers 0, `count`=0, `empty`=1, `almost_empty`=1.
  - `full`=0, `almost_full`=0, `overflow`=0, `underflow`=0, `rd_valid`=0, state EMPTY.
  - `rst` has priority over `flush`, push and pop.
- **Status update.** `count` and all flags update on the edge that accepts the push or pop, so they are visible the following cycle.
- **RAM contract.** The RAM samples `we`/`wr_addr`/`din` and `re`/`rd_addr` on the rising edge. `dout` is valid from the following cycle.
- **Read latency: 1 cycle.** `rd_valid` is registered `pop_ok`. It is high in the cycle after the accepted pop, for exactly one cycle per pop.
- **Back-to-back.** One push and one pop can be accepted every cycle.
- **Reset or flush mid-read.** If asserted in the cycle a pop is requested, no `rd_valid` follows.

## Structure
- **Shared package/header `fifo_pkg`.** Holds default WIDTH/DEPTH/ADDR_BUS, AF/AE defaults, and the state encodings (EMPTY=2'd0, PARTIAL=2'd1, FULL=2'd2).
- **Sub-module `fifo_ptr`.** An ADDR_BUS+1-bit incrementer with enable and synchronous clear, instantiated twice (write and read pointer).
- **Top-level `sync_fifo_8x16`.** Connects this controller to the RAM. It is owned separately and is out of scope for this block.

## Test plan
- **Reset.** Assert `rst` for 1 cycle -> `empty`=1, `count`=0, `full`=0, `rd_valid`=0, both error flags 0.
- **Fill.** Push 8 words 16'h0001..16'h0008 on consecutive cycles -> `ram_wr_addr` goes 0..7, `count`=8, `full`=1, `almost_full` first asserted at count 6.
- **Overflow.** Push 16'hDEAD while full -> `ram_we`=0, `count` stays 8, `overflow`=1 and sticky.
- **Drain with wrap.** Pop 8 times -> `rd_valid` one cycle after each pop, `rd_data` 16'h0001..16'h0008 in order, then `empty`=1. A ninth pop sets `underflow`.
- **Concurrent push/pop.** At count=3, push and pop together for 10 cycles -> `count` stays 3, pointers cross 8 (MSB toggles), data order preserved.
- **Flush.** At count=5, assert `flush` together with push and pop -> `ram_we`=`ram_re`=0, next cycle `count`=0, `empty`=1, no `rd_valid`, error flags unchanged.
